acc_feed: RTL and testbench

Operand feeder placed directly upstream of the 8-bit accumulator. It buffers incoming 8-bit operands and carry-ins in a small FIFO. On `start` it clears the accumulator, then presents exactly `BURST` operands on the accumulator's `accin`/`cin` inputs, one per cycle whenever data is available. It also counts the accumulator's carry-outs over the burst and flags completion.

---
 rtl/acc_feed.sv | 120 ++++++++++++
 tb/tb_acc_feed.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_feed.sv
// Operand feeder for the 8-bit accumulator: buffers {cin, data} pairs in a small FIFO,
// then on start clears the accumulator and streams BURST operands while counting carry-outs.
module acc_feed #(
  parameter int DEPTH = 4,
  parameter int BURST = 8
) (
  input  logic       clk,
  input  logic       clear,
  input  logic [7:0] in_data,
  input  logic       in_cin,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       start,
  output logic [7:0] accin,
  output logic       cin,
  input  logic       cout,
  output logic       acc_clear,
  output logic       busy,
  output logic       done,
  output logic [7:0] carry_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [7:0] BurstLim = 8'(BURST);
  localparam logic [AW:0] PtrOne = (AW + 1)'(1);

  typedef enum logic [1:0] {
    IDLE,
    CLR,
    RUN,
    DONE
  } state_t;

  state_t      state_q;
  logic [8:0]  mem_q [DEPTH];
  logic [AW:0] wptr_q, rptr_q;
  logic [AW:0] wptr_d, rptr_d;
  logic [7:0]  issued_q;
  logic [7:0]  carry_cnt_q;
  logic        acc_clear_q;
  logic        done_q;
  logic        full, empty, push, issue;
  logic [8:0]  head;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign push  = in_valid && !full;
  assign issue = (state_q == RUN) && !empty && (issued_q < BurstLim);
  assign head  = mem_q[rptr_q[AW-1:0]];

  assign in_ready  = !full;
  assign accin     = issue ? head[7:0] : 8'h00;
  assign cin       = issue && head[8];
  assign acc_clear = acc_clear_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign carry_cnt = carry_cnt_q;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push) wptr_d = wptr_q + PtrOne;
    if (issue) rptr_d = rptr_q + PtrOne;
  end

  always_ff @(posedge clk) begin
    if (push && !clear) mem_q[wptr_q[AW-1:0]] <= {in_cin, in_data};
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Burst sequencer; acc_clear and done are registered alongside the state they belong to.
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q     <= IDLE;
      issued_q    <= 8'd0;
      carry_cnt_q <= 8'd0;
      acc_clear_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      acc_clear_q <= 1'b0;
      done_q      <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q     <= CLR;
            acc_clear_q <= 1'b1;
          end
        end
        CLR: begin
          state_q     <= RUN;
          issued_q    <= 8'd0;
          carry_cnt_q <= 8'd0;
        end
        RUN: begin
          if (issue) begin
            issued_q <= issued_q + 8'd1;
            if (cout && carry_cnt_q != 8'hFF) carry_cnt_q <= carry_cnt_q + 8'd1;
            if (issued_q == BurstLim - 8'd1) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_acc_feed.sv
// Directed bench for acc_feed with a behavioural 8-bit accumulator model downstream.
module tb_acc_feed;

  logic       clk = 1'b0;
  logic       clear;
  logic [7:0] in_data;
  logic       in_cin;
  logic       in_valid;
  logic       in_ready;
  logic       start;
  logic [7:0] accin;
  logic       cin;
  logic       cout;
  logic       acc_clear;
  logic       busy;
  logic       done;
  logic [7:0] carry_cnt;

  logic [7:0] accout;
  logic [8:0] accSum;

  int nChecks = 0;
  int nFail   = 0;
  int cyc     = 0;
  bit feedEn  = 1'b0;
  logic [8:0] feedQ[$];

  acc_feed #(.DEPTH(4), .BURST(8)) dut (
    .clk(clk), .clear(clear), .in_data(in_data), .in_cin(in_cin),
    .in_valid(in_valid), .in_ready(in_ready), .start(start),
    .accin(accin), .cin(cin), .cout(cout), .acc_clear(acc_clear),
    .busy(busy), .done(done), .carry_cnt(carry_cnt)
  );

  always #5 clk = ~clk;

  // Accumulator model: registers accout + accin + cin, carry-out is combinational.
  assign accSum = {1'b0, accout} + {1'b0, accin} + {8'b0, cin};
  assign cout   = accSum[8];
  always @(posedge clk) begin
    if (clear || acc_clear) accout <= 8'h00;
    else accout <= accSum[7:0];
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nChecks++;
    if (observed !== expected) begin
      nFail++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  // One clock: drive the producer, take the edge, retire accepted operands, return at negedge.
  task automatic applyStimulus();
    bit accepted;
    if (feedEn) begin
      if (feedQ.size() > 0) begin
        in_valid = 1'b1;
        in_data  = feedQ[0][7:0];
        in_cin   = feedQ[0][8];
      end else begin
        in_valid = 1'b0;
      end
    end
    accepted = feedEn && in_valid && in_ready;
    @(posedge clk);
    if (accepted) void'(feedQ.pop_front());
    @(negedge clk);
    cyc++;
  endtask

  // Observes a burst from cycle tStart+2 onward until done, checking order, timing and result.
  task automatic runBurst(input string tag, input logic [8:0] exp [8], input logic [7:0] expAcc,
                          input logic [7:0] expCarry, input int tStart, input bit chkReady);
    int n = 0;
    bit gotDone = 1'b0;
    for (int c = 0; c < 60 && !gotDone; c++) begin
      if (done) begin
        gotDone = 1'b1;
      end else begin
        if (chkReady && cyc == tStart + 2) checkOutput({tag, "_ready_pop"}, 32'(in_ready), 32'd0);
        if (chkReady && cyc == tStart + 3) checkOutput({tag, "_ready_rise"}, 32'(in_ready), 32'd1);
        if ({cin, accin} != 9'h000) begin
          if (n < 8) checkOutput({tag, "_operand"}, 32'({cin, accin}), 32'(exp[n]));
          checkOutput({tag, "_issue_cycle"}, 32'(cyc), 32'(tStart + 2 + n));
          n++;
        end
        applyStimulus();
      end
    end
    if (!gotDone) begin
      checkOutput({tag, "_done_timeout"}, 32'd0, 32'd1);
    end else begin
      checkOutput({tag, "_done_cycle"}, 32'(cyc), 32'(tStart + 10));
      checkOutput({tag, "_issue_count"}, 32'(n), 32'd8);
      checkOutput({tag, "_accout"}, 32'(accout), 32'(expAcc));
      checkOutput({tag, "_carry_cnt"}, 32'(carry_cnt), 32'(expCarry));
      applyStimulus();
      checkOutput({tag, "_busy_after"}, 32'(busy), 32'd0);
      checkOutput({tag, "_done_pulse"}, 32'(done), 32'd0);
      checkOutput({tag, "_carry_hold"}, 32'(carry_cnt), 32'(expCarry));
    end
  endtask

  task automatic startBurst(input string tag, output int tStart);
    tStart = cyc;
    start = 1'b1;
    applyStimulus();
    start = 1'b0;
    checkOutput({tag, "_acc_clear"}, 32'(acc_clear), 32'd1);
    checkOutput({tag, "_busy_clr"}, 32'(busy), 32'd1);
    applyStimulus();
    checkOutput({tag, "_acc_clear_1cyc"}, 32'(acc_clear), 32'd0);
  endtask

  initial begin
    logic [8:0] exp [8];
    logic [7:0] expAcc;
    int tStart;

    clear = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_cin = 1'b0;
    @(negedge clk);

    // Reset with random inputs
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'($urandom); start = 1'($urandom);
      in_data = 8'($urandom); in_cin = 1'($urandom);
      applyStimulus();
      checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
      checkOutput("rst_accin", 32'({cin, accin}), 32'd0);
      checkOutput("rst_acc_clear", 32'(acc_clear), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_done", 32'(done), 32'd0);
      checkOutput("rst_carry_cnt", 32'(carry_cnt), 32'd0);
    end
    clear = 1'b0; start = 1'b0; in_valid = 1'b0;
    feedEn = 1'b1;
    feedQ.push_back(9'h005);
    applyStimulus();
    checkOutput("rst_push_accepted", 32'(feedQ.size()), 32'd0);
    checkOutput("rst_push_ready", 32'(in_ready), 32'd1);
    feedEn = 1'b0; in_valid = 1'b0;
    clear = 1'b1;
    applyStimulus();
    clear = 1'b0;
    checkOutput("rst_flush_ready", 32'(in_ready), 32'd1);

    // Nominal burst 0x10..0x17
    for (int i = 0; i < 8; i++) begin
      feedQ.push_back(9'(8'h10 + i));
      exp[i] = 9'(8'h10 + i);
    end
    feedEn = 1'b1;
    repeat (4) applyStimulus();
    checkOutput("nom_preload_full", 32'(in_ready), 32'd0);
    startBurst("nom", tStart);
    runBurst("nom", exp, 8'h9C, 8'd0, tStart, 1'b0);

    // Carry burst: 0xFF with cin=1
    for (int i = 0; i < 8; i++) begin
      feedQ.push_back(9'h1FF);
      exp[i] = 9'h1FF;
    end
    repeat (4) applyStimulus();
    startBurst("cry", tStart);
    runBurst("cry", exp, 8'h00, 8'd8, tStart, 1'b0);

    // Starvation: one operand every 3 cycles into an empty FIFO
    feedEn = 1'b0; in_valid = 1'b0;
    startBurst("stv", tStart);
    expAcc = 8'h00;
    for (int i = 0; i < 8; i++) begin
      checkOutput("stv_gap_accin", 32'({cin, accin}), 32'd0);
      checkOutput("stv_gap_hold", 32'(accout), 32'(expAcc));
      checkOutput("stv_gap_done", 32'(done), 32'd0);
      in_valid = 1'b1; in_data = 8'h21 + 8'(i); in_cin = 1'b0;
      applyStimulus();
      in_valid = 1'b0;
      checkOutput("stv_issue", 32'({cin, accin}), 32'(8'h21 + 8'(i)));
      applyStimulus();
      expAcc = expAcc + 8'h21 + 8'(i);
      checkOutput("stv_post_accin", 32'({cin, accin}), 32'd0);
      checkOutput("stv_post_acc", 32'(accout), 32'(expAcc));
      checkOutput("stv_done", 32'(done), (i == 7) ? 32'd1 : 32'd0);
      if (i == 7) checkOutput("stv_carry_cnt", 32'(carry_cnt), 32'd1);
      applyStimulus();
    end
    checkOutput("stv_final_acc", 32'(accout), 32'h24);
    checkOutput("stv_busy_after", 32'(busy), 32'd0);

    // Backpressure: 6 offered in IDLE, only 4 fit
    for (int i = 0; i < 8; i++) begin
      exp[i] = {(i == 2 || i == 5) ? 1'b1 : 1'b0, 8'h31 + 8'(i)};
      if (i < 6) feedQ.push_back(exp[i]);
    end
    feedEn = 1'b1;
    repeat (6) applyStimulus();
    checkOutput("bp_accepted", 32'(feedQ.size()), 32'd2);
    checkOutput("bp_ready_low", 32'(in_ready), 32'd0);
    feedQ.push_back(exp[6]);
    feedQ.push_back(exp[7]);
    startBurst("bp", tStart);
    runBurst("bp", exp, 8'hA6, 8'd1, tStart, 1'b1);

    // Mid-burst clear after 3 issues
    for (int i = 0; i < 4; i++) feedQ.push_back(9'(8'h91 + i));
    repeat (4) applyStimulus();
    feedEn = 1'b0; in_valid = 1'b0;
    startBurst("mid", tStart);
    for (int i = 0; i < 3; i++) begin
      checkOutput("mid_issue", 32'({cin, accin}), 32'(8'h91 + 8'(i)));
      applyStimulus();
    end
    checkOutput("mid_carry_before", 32'(carry_cnt), 32'd1);
    clear = 1'b1;
    applyStimulus();
    clear = 1'b0;
    checkOutput("mid_busy", 32'(busy), 32'd0);
    checkOutput("mid_ready", 32'(in_ready), 32'd1);
    checkOutput("mid_carry_cnt", 32'(carry_cnt), 32'd0);
    checkOutput("mid_accin", 32'({cin, accin}), 32'd0);
    checkOutput("mid_no_done", 32'(done), 32'd0);
    applyStimulus();
    checkOutput("mid_no_done_late", 32'(done), 32'd0);
    for (int i = 0; i < 8; i++) begin
      exp[i] = 9'(8'h51 + i);
      feedQ.push_back(exp[i]);
    end
    feedEn = 1'b1;
    repeat (4) applyStimulus();
    startBurst("mid2", tStart);
    runBurst("mid2", exp, 8'hA4, 8'd2, tStart, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
